branch_resolve_unit: RTL and testbench

- EX-stage block that resolves conditional and unconditional branches against the IF-stage prediction.
- Produces the update and miss interface that drives the branch predictor: PredictionMiss, ShouldBranch, BranchSourceAddress and BranchTargetAddress.
- On a misprediction it issues the PC redirect and runs a timed flush of the wrong-path stages.
- Sits between the ID/EX pipeline register and the branch predictor / PC mux.

---
 rtl/branch_resolve_unit.sv | 187 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//   EX-stage branch resolution. Compares the actual branch outcome against the
//   IF-stage prediction, reports every resolved branch to the predictor, and on
//   a misprediction issues a PC redirect and holds FlushIF/FlushID for
//   FlushCycles unstalled cycles.
//
// Optional feature: define BRANCH_RESOLVE_PERF_EN to add saturating 16-bit
//   BranchCount / MissCount counters and the PerfClear input.
//
// Ports
//   CLK, RST             clock (rising edge), async active-low reset
//   Stall                freezes all state and outputs
//   BranchValid          EX instruction is a branch to resolve
//   BranchCond[2:0]      condition select
//   FlagZ/FlagN/FlagC    ALU flags
//   PredictedTaken       IF prediction
//   PredictedAddress     address fetched by IF after the branch
//   SourceAddress        PC of the branch
//   PCPlusOne            fall-through address
//   ComputedTarget       resolved target
//   UpdateValid          strobe: resolved branch reported
//   ShouldBranch         actual outcome
//   PredictionMiss       strobe: branch was mispredicted
//   BranchSourceAddress  registered SourceAddress
//   BranchTargetAddress  registered ComputedTarget
//   RedirectAddress      correct next PC, valid with PredictionMiss
//   FlushIF, FlushID     squash wrong-path stages
//   Busy                 FSM in FLUSH
//
// States
//   IDLE  | accepting branches
//   FLUSH | wrong-path squash in progress, branches ignored
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int AddrBits    = 16,
    parameter int FlushCycles = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Stall,
    input  logic                BranchValid,
    input  logic [2:0]          BranchCond,
    input  logic                FlagZ,
    input  logic                FlagN,
    input  logic                FlagC,
    input  logic                PredictedTaken,
    input  logic [AddrBits-1:0] PredictedAddress,
    input  logic [AddrBits-1:0] SourceAddress,
    input  logic [AddrBits-1:0] PCPlusOne,
    input  logic [AddrBits-1:0] ComputedTarget,
`ifdef BRANCH_RESOLVE_PERF_EN
    input  logic                PerfClear,
    output logic [15:0]         BranchCount,
    output logic [15:0]         MissCount,
`endif
    output logic                UpdateValid,
    output logic                ShouldBranch,
    output logic                PredictionMiss,
    output logic [AddrBits-1:0] BranchSourceAddress,
    output logic [AddrBits-1:0] BranchTargetAddress,
    output logic [AddrBits-1:0] RedirectAddress,
    output logic                FlushIF,
    output logic                FlushID,
    output logic                Busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] FlushInit = 4'(FlushCycles - 1);

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                upd_q;
    logic                taken_q;
    logic                miss_q;
    logic                flush_q;
    logic [AddrBits-1:0] src_q;
    logic [AddrBits-1:0] tgt_q;
    logic [AddrBits-1:0] redir_q;

    logic                taken_d;
    logic                miss_d;
    logic                accept;

    always_comb begin
        taken_d = 1'b0;
        case (BranchCond)
            3'b000:  taken_d = FlagZ;
            3'b001:  taken_d = ~FlagZ;
            3'b010:  taken_d = FlagN;
            3'b011:  taken_d = ~FlagN;
            3'b100:  taken_d = FlagC;
            3'b101:  taken_d = ~FlagC;
            3'b110:  taken_d = 1'b1;
            default: taken_d = 1'b0;
        endcase
    end

    // A correctly predicted taken branch still misses if IF fetched the wrong target.
    assign miss_d = (taken_d != PredictedTaken) |
                    (taken_d & PredictedTaken & (PredictedAddress != ComputedTarget));

    assign accept = ~Stall & BranchValid & (state_q == IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            upd_q   <= 1'b0;
            taken_q <= 1'b0;
            miss_q  <= 1'b0;
            flush_q <= 1'b0;
            src_q   <= '0;
            tgt_q   <= '0;
            redir_q <= '0;
        end else if (!Stall) begin
            upd_q  <= 1'b0;
            miss_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (BranchValid) begin
                        upd_q   <= 1'b1;
                        taken_q <= taken_d;
                        src_q   <= SourceAddress;
                        tgt_q   <= ComputedTarget;
                        if (miss_d) begin
                            miss_q  <= 1'b1;
                            redir_q <= taken_d ? ComputedTarget : PCPlusOne;
                            flush_q <= 1'b1;
                            cnt_q   <= FlushInit;
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (cnt_q == 4'd0) begin
                        flush_q <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    flush_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign UpdateValid         = upd_q;
    assign ShouldBranch        = taken_q;
    assign PredictionMiss      = miss_q;
    assign BranchSourceAddress = src_q;
    assign BranchTargetAddress = tgt_q;
    assign RedirectAddress     = redir_q;
    assign FlushIF             = flush_q;
    assign FlushID             = flush_q;
    assign Busy                = (state_q == FLUSH);

`ifdef BRANCH_RESOLVE_PERF_EN
    logic [15:0] bcnt_q;
    logic [15:0] mcnt_q;

    // Counted on the edge that raises the strobe, so a stalled strobe counts once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bcnt_q <= '0;
            mcnt_q <= '0;
        end else if (PerfClear) begin
            bcnt_q <= '0;
            mcnt_q <= '0;
        end else if (accept) begin
            if (bcnt_q != 16'hFFFF) bcnt_q <= bcnt_q + 16'd1;
            if (miss_d && (mcnt_q != 16'hFFFF)) mcnt_q <= mcnt_q + 16'd1;
        end
    end

    assign BranchCount = bcnt_q;
    assign MissCount   = mcnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam int AW = 16;
    localparam int FC = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          Stall = 1'b0;
    logic          BranchValid = 1'b0;
    logic [2:0]    BranchCond = '0;
    logic          FlagZ = 1'b0, FlagN = 1'b0, FlagC = 1'b0;
    logic          PredictedTaken = 1'b0;
    logic [AW-1:0] PredictedAddress = '0, SourceAddress = '0, PCPlusOne = '0, ComputedTarget = '0;
    logic          UpdateValid, ShouldBranch, PredictionMiss, FlushIF, FlushID, Busy;
    logic [AW-1:0] BranchSourceAddress, BranchTargetAddress, RedirectAddress;
`ifdef BRANCH_RESOLVE_PERF_EN
    logic          PerfClear = 1'b0;
    logic [15:0]   BranchCount, MissCount;
`endif

    int tests = 0;
    int fails = 0;
    logic [AW-1:0] exp_redir = '0;

    branch_resolve_unit #(.AddrBits(AW), .FlushCycles(FC)) dut (
        .CLK(CLK), .RST(RST), .Stall(Stall), .BranchValid(BranchValid),
        .BranchCond(BranchCond), .FlagZ(FlagZ), .FlagN(FlagN), .FlagC(FlagC),
        .PredictedTaken(PredictedTaken), .PredictedAddress(PredictedAddress),
        .SourceAddress(SourceAddress), .PCPlusOne(PCPlusOne), .ComputedTarget(ComputedTarget),
`ifdef BRANCH_RESOLVE_PERF_EN
        .PerfClear(PerfClear), .BranchCount(BranchCount), .MissCount(MissCount),
`endif
        .UpdateValid(UpdateValid), .ShouldBranch(ShouldBranch), .PredictionMiss(PredictionMiss),
        .BranchSourceAddress(BranchSourceAddress), .BranchTargetAddress(BranchTargetAddress),
        .RedirectAddress(RedirectAddress), .FlushIF(FlushIF), .FlushID(FlushID), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    // Reference: outcome from the condition table, miss from the prediction rule.
    function automatic logic ref_taken(input logic [2:0] c, input logic z, input logic n, input logic cf);
        logic [7:0] table_v;
        table_v = {1'b0, 1'b1, ~cf, cf, ~n, n, ~z, z};
        return table_v[c];
    endfunction

    function automatic logic ref_miss(input logic t, input logic pt, input logic [AW-1:0] pa,
                                      input logic [AW-1:0] tg);
        if (t != pt) return 1'b1;
        if (t && pa != tg) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_branch(input logic [2:0] c, input logic z, input logic n, input logic cf,
                              input logic pt, input logic [AW-1:0] pa, input logic [AW-1:0] src,
                              input logic [AW-1:0] tg);
        BranchCond = c; FlagZ = z; FlagN = n; FlagC = cf;
        PredictedTaken = pt; PredictedAddress = pa;
        SourceAddress = src; PCPlusOne = src + 16'd1; ComputedTarget = tg;
        BranchValid = 1'b1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (Busy === 1'b1 && k < 50) begin
            BranchValid = 1'b0;
            step();
            k++;
        end
        tests++;
        if (Busy !== 1'b0) begin
            fails++;
            $display("FAIL wait_idle: Busy=%b after %0d cycles, required 0", Busy, k);
        end
        BranchValid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if ({UpdateValid, ShouldBranch, PredictionMiss, FlushIF, FlushID, Busy} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b required 000000",
                     {UpdateValid, ShouldBranch, PredictionMiss, FlushIF, FlushID, Busy});
        end
        tests++;
        if ({BranchSourceAddress, BranchTargetAddress, RedirectAddress} !== '0) begin
            fails++;
            $display("FAIL reset_addr: src=%h tgt=%h redir=%h required 0",
                     BranchSourceAddress, BranchTargetAddress, RedirectAddress);
        end
        @(negedge CLK);
        RST = 1'b1;
        step();
    endtask

    task automatic test_correct_taken();
        set_branch(3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0040, 16'h0010, 16'h0040);
        step();
        BranchValid = 1'b0;
        tests++;
        if ({UpdateValid, ShouldBranch, PredictionMiss, FlushIF, Busy} !== 5'b11000) begin
            fails++;
            $display("FAIL correct_taken_flags: got %b required 11000",
                     {UpdateValid, ShouldBranch, PredictionMiss, FlushIF, Busy});
        end
        tests++;
        if (BranchTargetAddress !== 16'h0040 || BranchSourceAddress !== 16'h0010) begin
            fails++;
            $display("FAIL correct_taken_addr: tgt=%h src=%h required 0040 0010",
                     BranchTargetAddress, BranchSourceAddress);
        end
        step();
        tests++;
        if (UpdateValid !== 1'b0) begin
            fails++;
            $display("FAIL strobe_clear: UpdateValid=%b required 0", UpdateValid);
        end
    endtask

    task automatic test_not_taken_miss();
        int n;
        set_branch(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0040, 16'h0010, 16'h0040);
        step();
        BranchValid = 1'b0;
        exp_redir = 16'h0011;
        tests++;
        if ({UpdateValid, ShouldBranch, PredictionMiss, FlushIF, FlushID, Busy} !== 6'b101111 ||
            RedirectAddress !== 16'h0011) begin
            fails++;
            $display("FAIL nt_miss: flags=%b redir=%h required 101111 0011",
                     {UpdateValid, ShouldBranch, PredictionMiss, FlushIF, FlushID, Busy}, RedirectAddress);
        end
        n = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (FlushIF !== 1'b1) break;
            n++;
        end
        tests++;
        if (n != FC || FlushID !== 1'b0 || Busy !== 1'b0) begin
            fails++;
            $display("FAIL nt_miss_flush_len: got %0d cycles (FlushID=%b Busy=%b) required %0d",
                     n, FlushID, Busy, FC);
        end
    endtask

    task automatic test_target_mismatch();
        set_branch(3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0030, 16'h0020, 16'h0031);
        step();
        BranchValid = 1'b0;
        exp_redir = 16'h0031;
        tests++;
        if (PredictionMiss !== 1'b1 || ShouldBranch !== 1'b1 || RedirectAddress !== 16'h0031) begin
            fails++;
            $display("FAIL target_mismatch: miss=%b taken=%b redir=%h required 1 1 0031",
                     PredictionMiss, ShouldBranch, RedirectAddress);
        end
        wait_idle();
    endtask

    task automatic test_flush_stall();
        int n;
        logic [AW-1:0] src_hold;
        set_branch(3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0100, 16'h0200);
        step();
        exp_redir = 16'h0200;
        src_hold = BranchSourceAddress;
        n = 1;
        set_branch(3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0300, 16'h0400);
        step();
        n++;
        tests++;
        if (UpdateValid !== 1'b0 || PredictionMiss !== 1'b0 || Busy !== 1'b1) begin
            fails++;
            $display("FAIL flush_ignore_branch: upd=%b miss=%b busy=%b required 0 0 1",
                     UpdateValid, PredictionMiss, Busy);
        end
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n++;
            tests++;
            if (FlushIF !== 1'b1 || UpdateValid !== 1'b0 || BranchSourceAddress !== src_hold) begin
                fails++;
                $display("FAIL stall_hold: flush=%b upd=%b src=%h required 1 0 %h",
                         FlushIF, UpdateValid, BranchSourceAddress, src_hold);
            end
        end
        Stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (FlushIF !== 1'b1) break;
            n++;
        end
        BranchValid = 1'b0;
        tests++;
        if (n != FC + 3) begin
            fails++;
            $display("FAIL flush_stall_len: got %0d cycles required %0d", n, FC + 3);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_flush();
        set_branch(3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0050, 16'h0060, 16'h0050);
        step();
        BranchValid = 1'b0;
        step();
        #2;
        RST = 1'b0;
        #1;
        exp_redir = '0;
        tests++;
        if ({UpdateValid, ShouldBranch, PredictionMiss, FlushIF, FlushID, Busy} !== 6'b0 ||
            {BranchSourceAddress, BranchTargetAddress, RedirectAddress} !== '0) begin
            fails++;
            $display("FAIL reset_mid_flush: flags=%b src=%h tgt=%h redir=%h required all 0",
                     {UpdateValid, ShouldBranch, PredictionMiss, FlushIF, FlushID, Busy},
                     BranchSourceAddress, BranchTargetAddress, RedirectAddress);
        end
        @(negedge CLK);
        RST = 1'b1;
        set_branch(3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0070, 16'h0071, 16'h0070);
        step();
        BranchValid = 1'b0;
        tests++;
        if ({UpdateValid, PredictionMiss, FlushIF, Busy} !== 4'b1000) begin
            fails++;
            $display("FAIL after_reset_branch: got %b required 1000",
                     {UpdateValid, PredictionMiss, FlushIF, Busy});
        end
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            set_branch(3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1000 + 16'(i), 16'h0a00 + 16'(i),
                       16'h1000 + 16'(i));
            step();
            tests++;
            if (UpdateValid !== 1'b1 || PredictionMiss !== 1'b0 ||
                BranchSourceAddress !== 16'h0a00 + 16'(i)) begin
                fails++;
                $display("FAIL back_to_back[%0d]: upd=%b miss=%b src=%h required 1 0 %h",
                         i, UpdateValid, PredictionMiss, BranchSourceAddress, 16'h0a00 + 16'(i));
            end
        end
        BranchValid = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [2:0] c;
        logic z, n, cf, pt, t, m;
        logic [AW-1:0] pa, src, tg;
        int stalls, len;
        for (int it = 0; it < 150; it++) begin
            wait_idle();
            c = 3'($urandom_range(0, 7));
            z = 1'($urandom); n = 1'($urandom); cf = 1'($urandom); pt = 1'($urandom);
            src = 16'($urandom); tg = 16'($urandom);
            pa = ($urandom_range(0, 3) != 0) ? tg : 16'($urandom);
            t = ref_taken(c, z, n, cf);
            m = ref_miss(t, pt, pa, tg);
            if (m) exp_redir = t ? tg : src + 16'd1;
            set_branch(c, z, n, cf, pt, pa, src, tg);
            step();
            BranchValid = 1'($urandom);
            tests++;
            if (UpdateValid !== 1'b1 || ShouldBranch !== t || PredictionMiss !== m ||
                FlushIF !== m || BranchSourceAddress !== src || BranchTargetAddress !== tg ||
                RedirectAddress !== exp_redir) begin
                fails++;
                $display("FAIL rand[%0d]: upd=%b tk=%b miss=%b fl=%b src=%h tgt=%h rd=%h required 1 %b %b %b %h %h %h",
                         it, UpdateValid, ShouldBranch, PredictionMiss, FlushIF, BranchSourceAddress,
                         BranchTargetAddress, RedirectAddress, t, m, m, src, tg, exp_redir);
            end
            stalls = $urandom_range(0, 2);
            Stall = (stalls != 0);
            for (int s = 0; s < stalls; s++) begin
                step();
                tests++;
                if (UpdateValid !== 1'b1 || PredictionMiss !== m) begin
                    fails++;
                    $display("FAIL rand_stall_hold[%0d]: upd=%b miss=%b required 1 %b",
                             it, UpdateValid, PredictionMiss, m);
                end
            end
            Stall = 1'b0;
            if (m) begin
                len = 1 + stalls;
                for (int k = 0; k < 30; k++) begin
                    step();
                    if (UpdateValid !== 1'b0 || PredictionMiss !== 1'b0) begin
                        tests++;
                        fails++;
                        $display("FAIL rand_flush_strobe[%0d]: upd=%b miss=%b required 0 0",
                                 it, UpdateValid, PredictionMiss);
                    end
                    if (FlushIF !== 1'b1) break;
                    len++;
                end
                tests++;
                if (len != FC + stalls) begin
                    fails++;
                    $display("FAIL rand_flush_len[%0d]: got %0d required %0d", it, len, FC + stalls);
                end
            end else if (BranchValid) begin
                BranchValid = 1'b0;
            end
        end
        BranchValid = 1'b0;
        wait_idle();
        step();
    endtask

`ifdef BRANCH_RESOLVE_PERF_EN
    task automatic test_perf();
        PerfClear = 1'b1;
        step();
        PerfClear = 1'b0;
        tests++;
        if (BranchCount !== 16'd0 || MissCount !== 16'd0) begin
            fails++;
            $display("FAIL perf_clear0: bc=%0d mc=%0d required 0 0", BranchCount, MissCount);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 1 || i == 3)
                set_branch(3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0200, 16'h0300);
            else
                set_branch(3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0300, 16'h0200, 16'h0300);
            step();
            BranchValid = 1'b0;
            wait_idle();
        end
        tests++;
        if (BranchCount !== 16'd5 || MissCount !== 16'd2) begin
            fails++;
            $display("FAIL perf_counts: bc=%0d mc=%0d required 5 2", BranchCount, MissCount);
        end
        PerfClear = 1'b1;
        step();
        PerfClear = 1'b0;
        tests++;
        if (BranchCount !== 16'd0 || MissCount !== 16'd0) begin
            fails++;
            $display("FAIL perf_clear: bc=%0d mc=%0d required 0 0", BranchCount, MissCount);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_correct_taken();
        test_not_taken_miss();
        test_target_mismatch();
        test_flush_stall();
        test_back_to_back();
        test_reset_mid_flush();
        test_random();
`ifdef BRANCH_RESOLVE_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
